// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART constants and receiver FSM state encoding
package uart_defs;

    localparam int CLK_FREQ_HZ          = 100_000_000;
    localparam int BAUD_RATE            = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous single-bit inputs
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_rx
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_serialRX,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frameErr,
    output logic       o_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic             w_rx_s;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_busy;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_serialRX),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    // A line that is high again at mid-start was only a glitch
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets an immediately following start edge be caught
                    if (r_cnt == BIT_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_frameErr = r_frame_err;
    assign o_busy     = r_busy;

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver for the Basys3 serial path, the receive-side counterpart of the transmit stage. It synchronises the asynchronous serial line and detects the start bit. Each bit is sampled at its midpoint, and the block presents each received byte with a one-cycle valid strobe and a framing-error flag. It sits directly downstream of the transmit stage's serial output, either in loopback or on the board's USB-UART RX pin.

## Interface
- CLKS_PER_BIT, 10417, clock cycles per bit period (100 MHz / 9600 baud); must be ≥ 8.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_serialRX  in  1  asynchronous serial line; idle high.
- o_data  out  8  last correctly framed byte; held until the next good byte.
- o_valid  out  1  one-cycle pulse when o_data is updated.
- o_frameErr  out  1  one-cycle pulse when the stop bit samples low.
- o_busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input synchroniser: two flip-flops, both reset to 1. rx_s is the second-stage output. The FSM only ever looks at rx_s.
- HALF = CLKS_PER_BIT/2 (integer division).
- Bit-period counter: clog2(CLKS_PER_BIT) bits wide. It is cleared on every state entry.
- bit_idx: 3 bits.
- Shift register: 8 bits, LSB first; the sampled bit is inserted at the MSB and the register shifts right.
- FSM states and transitions:
  - IDLE: when rx_s == 0, go to START with the counter at 0.
  - START: when the counter reaches HALF-1, sample rx_s. If it is 0, go to DATA with bit_idx = 0. If it is 1, the start was false (glitch): return to IDLE with no flags.
  - DATA: when the counter reaches CLKS_PER_BIT-1, shift in rx_s. If bit_idx == 7, go to STOP; otherwise increment bit_idx.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
    - If it is 1: o_data <= shift register, o_valid = 1 for that cycle, go to IDLE.
    - If it is 0: o_frameErr = 1 for that cycle, o_data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a held-low break from being decoded as 0x00 bytes.
- o_busy = (state != IDLE), registered alongside the state.
- o_valid and o_frameErr are never high in the same cycle.

## Timing
- Reset values: o_data = 8'h00, o_valid = 0, o_frameErr = 0, o_busy = 0, state = IDLE, synchroniser = 2'b11.
- Reset mid-frame: the next cycle is fully in the reset state. No o_valid is issued for the interrupted byte. Reception resumes with the next falling edge.
- Start detection latency: 2 cycles of synchroniser delay, plus 1 cycle to enter START.
- End-to-end latency: o_valid rises HALF + 9·CLKS_PER_BIT + 3 cycles after the pin's falling edge. The bench tolerates ±1 cycle of edge phase.
- Each data bit is sampled HALF + k·CLKS_PER_BIT cycles (k = 1..8) after the start is detected, i.e. at mid-bit.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends. A start edge that immediately follows the stop bit is therefore accepted with no lost cycles.
- A glitch on the line shorter than HALF cycles never produces o_valid, o_frameErr or data corruption.

## Structure
- Shared package/header `uart_defs`:
  - FSM state encodings (IDLE, START, DATA, STOP, WAIT_IDLE).
  - Default CLKS_PER_BIT and the 100 MHz clock constant, also used by the transmit stage.
- One natural sub-module: `sync_2ff`, a two-flop synchroniser with a reset value parameter. It is reusable for pushbutton and switch inputs.

## Test plan
- CLKS_PER_BIT = 16, send 0xA5 at nominal timing:
  - o_data = 8'hA5 and o_valid is high for exactly 1 cycle, 16/2 + 9·16 + 3 = 155 cycles (±1) after the start edge.
  - o_busy falls in the same cycle.
- Back-to-back 0x00 then 0xFF with no idle gap: two o_valid pulses 160 cycles apart, with data 8'h00 and 8'hFF. No frame errors.
- Drive the line low for 4 cycles, then high: o_busy pulses, then returns to 0. No o_valid or o_frameErr, and o_data keeps its previous value.
- Send 0x3C with the stop bit forced low, then hold the line low for 3 bit periods:
  - one o_frameErr pulse, o_data unchanged.
  - the FSM stays in WAIT_IDLE (o_busy = 1) until the line rises, and no spurious byte is received.
- Assert i_rst for 1 cycle during data bit 4 of a frame:
  - all outputs take their reset values on the next cycle, and no o_valid is issued for that frame.
  - the next frame, 0x81, is received correctly.
- Loopback: the transmit stage and uart_rx share CLKS_PER_BIT = 16; transmit 0x55, 0xAA and 0x0F in sequence. Each byte is received in order with exactly one o_valid per byte.
